// File: rtl/shift_add_mult_16_pkg.sv
// Shared definitions for the shift-and-add multiplier.
//   state_t : FSM state encoding (IDLE / RUN / DONE)
//   MULT_W  : operand width. The multiplier and its Add_rca must both use this width.
package shift_add_mult_16_pkg;

  localparam int MULT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage : shift_add_mult_16_pkg

// File: rtl/shift_add_mult_16_add_rca.sv
// Add_rca: plain ripple-carry adder. It is the only adder in the multiplier datapath.
// Ports:
//   a, b  : WIDTH-bit addends
//   c_in  : carry in
//   sum   : WIDTH-bit sum
//   c_out : carry out of the top bit
module Add_rca #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  logic [WIDTH:0] w_carry;

  assign w_carry[0] = c_in;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign sum[i]       = a[i] ^ b[i] ^ w_carry[i];
    assign w_carry[i+1] = (a[i] & b[i]) | (w_carry[i] & (a[i] ^ b[i]));
  end

  assign c_out = w_carry[WIDTH];

endmodule : Add_rca

// File: rtl/shift_add_mult_16.sv
// shift_add_mult_16: sequential 16x16 unsigned shift-and-add multiplier.
// It handles one multiply at a time. Each multiply takes 16 RUN cycles through a single Add_rca.
// Ports:
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset (release expected synchronous to clk)
//   in_valid  : operands a/b valid
//   in_ready  : registered, high only in IDLE
//   a, b      : multiplicand / multiplier
//   out_valid : registered, high only in DONE
//   out_ready : consumer accepts product
//   product   : registered 32-bit a*b, meaningful while out_valid is high
//   busy      : registered, high in RUN or DONE
module shift_add_mult_16
  import shift_add_mult_16_pkg::*;
#(
  parameter int WIDTH       = MULT_W,
  parameter bit BYPASS_ZERO = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  if (WIDTH != MULT_W) begin : g_bad_width
    $error("shift_add_mult_16: WIDTH must equal MULT_W (16)");
  end

  state_t               r_state;
  logic [2*WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]     r_m;
  logic [3:0]           r_cnt;
  logic                 r_in_ready;
  logic                 r_out_valid;
  logic                 r_busy;

  logic [WIDTH-1:0]     w_add_b;
  logic [WIDTH-1:0]     w_sum;
  logic                 w_cout;
  logic                 w_zero_op;

  // The high half of the accumulator holds the partial product. The low half holds the
  // multiplier bits that are not consumed yet, and acc[0] selects whether M is added this cycle.
  assign w_add_b   = r_acc[0] ? r_m : '0;
  assign w_zero_op = BYPASS_ZERO && ((a == '0) || (b == '0));

  Add_rca #(.WIDTH(WIDTH)) u_add (
    .a     (r_acc[2*WIDTH-1:WIDTH]),
    .b     (w_add_b),
    .c_in  (1'b0),
    .sum   (w_sum),
    .c_out (w_cout)
  );

  // Handshake flags are registered together with the state. They then follow the state
  // exactly, and no input reaches them combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_acc       <= '0;
      r_m         <= '0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid && r_in_ready) begin
            r_m        <= a;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            if (w_zero_op) begin
              r_acc       <= '0;
              r_state     <= ST_DONE;
              r_out_valid <= 1'b1;
            end else begin
              r_acc   <= {{WIDTH{1'b0}}, b};
              r_state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          // The carry becomes the new MSB. If it were dropped, the upper product bits would be wrong.
          r_acc <= {w_cout, w_sum, r_acc[WIDTH-1:1]};
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt == 4'(MULT_W - 1)) begin
            r_state     <= ST_DONE;
            r_out_valid <= 1'b1;
          end
        end
        ST_DONE: begin
          // in_ready is only re-armed here, so an accept can happen one edge later at the earliest.
          if (out_ready) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign product   = r_acc;

endmodule : shift_add_mult_16

// File: tb/tb_shift_add_mult_16.sv
module tb_shift_add_mult_16;

  logic        clk;
  logic        rst_n;

  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [15:0] a, b;
  logic [31:0] product;

  logic        nb_in_valid, nb_in_ready, nb_out_valid, nb_out_ready, nb_busy;
  logic [15:0] nb_a, nb_b;
  logic [31:0] nb_product;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  shift_add_mult_16 #(.WIDTH(16), .BYPASS_ZERO(1'b1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  shift_add_mult_16 #(.WIDTH(16), .BYPASS_ZERO(1'b0)) dut_nb (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (nb_in_valid),
    .in_ready  (nb_in_ready),
    .a         (nb_a),
    .b         (nb_b),
    .out_valid (nb_out_valid),
    .out_ready (nb_out_ready),
    .product   (nb_product),
    .busy      (nb_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Accept one operand pair on the selected instance and wait for out_valid.
  // lat is counted the way the block defines it: the cycle right after the accept edge is cycle 1.
  task automatic run_mult(input bit sel_nb, input logic [15:0] av, input logic [15:0] bv,
                          output logic [31:0] prod, output int lat);
    bit got_valid;
    @(negedge clk);
    if (sel_nb) begin
      nb_a = av; nb_b = bv; nb_in_valid = 1'b1; nb_out_ready = 1'b1;
    end else begin
      a = av; b = bv; in_valid = 1'b1; out_ready = 1'b1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; nb_in_valid = 1'b0;
    lat = 1;
    got_valid = sel_nb ? nb_out_valid : out_valid;
    while (!got_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      got_valid = sel_nb ? nb_out_valid : out_valid;
    end
    if (!got_valid) check("timeout_out_valid", 32'd0, 32'd1);
    prod = sel_nb ? nb_product : product;
    // out_ready is high, so the next edge completes the handshake
    @(posedge clk); #1;
  endtask

  logic [31:0] p;
  int          lat;
  int          t1, t2, k;

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
    nb_in_valid = 1'b0; nb_out_ready = 1'b1; nb_a = '0; nb_b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_product", product, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // 1: basic product and latency
    run_mult(1'b0, 16'd3, 16'd5, p, lat);
    check("t1_product", p, 32'h0000000F);
    check("t1_latency", lat, 17);

    // 2: all-ones operands, carry into bit 31
    run_mult(1'b0, 16'hFFFF, 16'hFFFF, p, lat);
    check("t2_product", p, 32'hFFFE0001);
    check("t2_latency", lat, 17);

    // 3: zero operand, with and without bypass
    run_mult(1'b0, 16'h0000, 16'h1234, p, lat);
    check("t3_bypass_product", p, 32'd0);
    check("t3_bypass_latency", lat, 1);
    run_mult(1'b1, 16'h0000, 16'h1234, p, lat);
    check("t3_nobypass_product", p, 32'd0);
    check("t3_nobypass_latency", lat, 17);

    // 4: backpressure in DONE; in_valid stays high with other operands and must be ignored
    @(negedge clk);
    a = 16'h00FF; b = 16'h0101; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    a = 16'd5; b = 16'd5;
    k = 0;
    while (!out_valid && k < 40) begin @(posedge clk); #1; k++; end
    check("t4_reach_done", {31'd0, out_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      check("t4_hold_product", product, 32'h0000FFFF);
      check("t4_hold_in_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
    end
    check("t4_still_valid", {31'd0, out_valid}, 32'd1);
    @(negedge clk); out_ready = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    check("t4_after_out_valid", {31'd0, out_valid}, 32'd0);
    check("t4_after_in_ready", {31'd0, in_ready}, 32'd1);
    check("t4_after_busy", {31'd0, busy}, 32'd0);

    // 5: reset pulse in the middle of RUN
    @(negedge clk);
    a = 16'd100; b = 16'd100; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("t5_busy_before_rst", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("t5_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("t5_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("t5_rst_busy", {31'd0, busy}, 32'd0);
    check("t5_rst_product", product, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    run_mult(1'b0, 16'd2, 16'd9, p, lat);
    check("t5_product", p, 32'd18);
    check("t5_latency", lat, 17);

    // 6: back-to-back with in_valid held high; operand changes during RUN must not matter
    @(negedge clk);
    a = 16'd7; b = 16'd6; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    a = 16'd40000; b = 16'd3;
    k = 0;
    while (!out_valid && k < 40) begin @(posedge clk); #1; k++; end
    t1 = cyc;
    check("t6_first_product", product, 32'd42);
    @(posedge clk); #1;
    check("t6_idle_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    check("t6_second_busy", {31'd0, busy}, 32'd1);
    a = 16'd1; b = 16'd1;
    k = 0;
    while (!out_valid && k < 40) begin @(posedge clk); #1; k++; end
    t2 = cyc;
    check("t6_second_product", product, 32'd120000);
    check("t6_spacing", t2 - t1, 18);
    in_valid = 1'b0;
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_shift_add_mult_16
